// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin time-share of one display word between N requesters
// Optional DISPLAY_ARBITER_BLANK_EN: blank, invalid gap of HOLD/4 cycles between owners.
module display_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 100000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   words,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         done,
  output logic [WIDTH-1:0]     disp_word,
  output logic                 disp_valid,
  output logic                 busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;
`ifdef DISPLAY_ARBITER_BLANK_EN
  localparam int BLANK = (HOLD / 4 > 0) ? HOLD / 4 : 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD, S_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [N-1:0]      done_q, done_d;
  logic [WIDTH-1:0]  disp_word_q, disp_word_d;
  logic              disp_valid_q, disp_valid_d;
  logic              busy_q, busy_d;

  logic              pick_found;
  logic [PW-1:0]     pick;
  logic [PW:0]       sum;
  logic [PW-1:0]     cand;
  logic [WIDTH-1:0]  pick_word;
  logic [PW-1:0]     ptr_next;

  // Rotating priority: first requester found scanning ptr, ptr+1, ... mod N.
  always_comb begin
    pick_found = 1'b0;
    pick       = ptr_q;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      cand = sum[PW-1:0];
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
    pick_word = '0;
    for (int i = 0; i < N; i++) begin
      if (pick == PW'(i)) pick_word = words[i*WIDTH +: WIDTH];
    end
  end

  assign ptr_next = (owner_q == PW'(N-1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    done_d       = '0;
    disp_word_d  = disp_word_q;
    disp_valid_d = disp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          disp_word_d   = pick_word;
          disp_valid_d  = 1'b1;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // A dropped request wins over window expiry: no done for an early leaver.
        if (!req[owner_q] || cnt_q == CW'(HOLD-2)) begin
          if (req[owner_q]) done_d[owner_q] = 1'b1;
          grant_d      = '0;
          disp_valid_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_RELEASE;
`ifdef DISPLAY_ARBITER_BLANK_EN
          disp_word_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
`ifdef DISPLAY_ARBITER_BLANK_EN
        if (cnt_q == CW'(BLANK)) begin
          ptr_d   = ptr_next;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        ptr_d   = ptr_next;
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      disp_word_q  <= '0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      disp_word_q  <= disp_word_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign disp_word  = disp_word_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - scoreboard bench for display_arbiter (N=4, WIDTH=8, HOLD=4)
module tb_display_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] words;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  disp_word;
  logic        disp_valid;
  logic        busy;

  display_arbiter #(.N(4), .WIDTH(8), .HOLD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .words      (words),
    .grant      (grant),
    .done       (done),
    .disp_word  (disp_word),
    .disp_valid (disp_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [7:0] w;
    int         len;
    logic [3:0] d;
    int         gap;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;
  int   win_cnt = 0;
  int   len = 0;
  int   gap = 0;
  logic [3:0] prev_g = '0;
  logic [3:0] dacc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] w, input int l,
                      input logic [3:0] d, input int gp);
    exp_t e;
    e.g = g; e.w = w; e.len = l; e.d = d; e.gap = gp;
    sb.push_back(e);
  endtask

  task automatic wait_windows(input int target);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (win_cnt >= target) break;
    end
    #1;
    if (win_cnt < target) check("window_timeout", win_cnt, target);
  endtask

  // Window monitor: each rising grant pops one expected window.
  always @(negedge clk) begin
    if (grant != 4'b0) begin
      if (prev_g == 4'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_grant", grant, 4'b0);
          cur.len = 0; cur.d = '0;
        end else begin
          cur = sb.pop_front();
          check("grant", grant, cur.g);
          check("disp_word", disp_word, cur.w);
          check("disp_valid", disp_valid, 1);
          check("busy", busy, 1);
          if (cur.gap >= 0) check("gap", gap, cur.gap);
        end
        len  = 1;
        dacc = done;
      end else begin
        len++;
        dacc = dacc | done;
      end
      gap = 0;
    end else begin
      if (prev_g != 4'b0) begin
        check("window_len", len, cur.len);
        check("done_while_granted", dacc, 0);
        check("done", done, cur.d);
        win_cnt++;
      end
      gap++;
    end
    prev_g = grant;
  end

  initial begin
    reset = 1'b0;
    req   = 4'b1111;
    words = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_disp_word", disp_word, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_done", done, 0);

    // Round robin across all four requesters.
    push(4'b0001, 8'h11, 4, 4'b0001, -1);
    push(4'b0010, 8'h22, 4, 4'b0010, 2);
    push(4'b0100, 8'h33, 4, 4'b0100, 2);
    push(4'b1000, 8'h44, 4, 4'b1000, 2);
    push(4'b0001, 8'h11, 4, 4'b0001, 2);
    reset = 1'b1;
    wait_windows(5);
    req = 4'b0000;

    // Single requester, re-granted after RELEASE + one IDLE cycle.
    @(posedge clk); #1;
    words = {8'h44, 8'hA5, 8'h22, 8'h11};
    push(4'b0100, 8'hA5, 4, 4'b0100, -1);
    push(4'b0100, 8'hA5, 4, 4'b0100, 2);
    req = 4'b0100;
    wait_windows(7);
    req = 4'b0000;
    check("persist_word", disp_word, 8'hA5);
    check("persist_valid", disp_valid, 0);
    check("persist_grant", grant, 0);

    // Early release by owner 1, then requester 2 takes over.
    @(posedge clk); #1;
    push(4'b0010, 8'h22, 3, 4'b0000, -1);
    push(4'b0100, 8'hA5, 4, 4'b0100, 2);
    req = 4'b0110;
    repeat (3) @(posedge clk);
    #1;
    req = 4'b0100;
    wait_windows(9);
    req = 4'b0000;

    // Data freeze while held; new word shows on the next grant.
    @(posedge clk); #1;
    push(4'b0001, 8'h11, 4, 4'b0001, -1);
    push(4'b0001, 8'h22, 4, 4'b0001, 2);
    req = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    words[7:0] = 8'h22;
    @(negedge clk);
    check("freeze_word", disp_word, 8'h11);
    wait_windows(11);
    req = 4'b0000;

    // Async reset mid-HOLD; pointer returns to 0.
    @(posedge clk); #1;
    push(4'b1000, 8'h44, 2, 4'b0000, -1);
    push(4'b0001, 8'h22, 4, 4'b0001, -1);
    req = 4'b1001;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_grant", grant, 0);
    check("async_done", done, 0);
    check("async_word", disp_word, 0);
    check("async_valid", disp_valid, 0);
    check("async_busy", busy, 0);
    #1;
    reset = 1'b1;
    wait_windows(13);
    req = 4'b0000;

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    check("final_grant", grant, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
